// File: rtl/serial_pkg.sv
// Shared types and elaboration helpers for the serial add/subtract datapath.
// Purely declarative; no logic, no latency, no flow control.
package serial_pkg;

  typedef enum logic {IDLE, RUN} ser_state_t;

  // Bit n set means DIGIT=n is a supported digit size (besides DIGIT=WIDTH).
  localparam logic [8:0] LEGAL_DIGIT_MASK = 9'b1_0001_0110;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    if (digit < 1 || width < 1 || (width % digit) != 0) return 1'b0;
    if (digit == width) return 1'b1;
    if (digit > 8) return 1'b0;
    return LEGAL_DIGIT_MASK[digit];
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit adder slice with carry out and carry into its MSB.
// Zero latency; no flow control.
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum   = total[DIGIT-1:0];
  assign cout  = total[DIGIT];
  // Recover the carry into the top bit from its own sum bit.
  assign c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial A+B / A-B, LSB first; done pulses WIDTH/DIGIT cycles after start.
// start is ignored while busy; result/flags hold until the next accepted start.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_addsub: illegal WIDTH/DIGIT combination");
  end

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             load, step, last;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dc_msb;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dc_msb)
  );

  if (DIGIT == WIDTH) begin : g_res_full
    assign res_shift = dsum;
  end else begin : g_res_shift
    assign res_shift = {dsum, result[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
        a_sr      <= data_a;
        b_sr      <= data_b ^ {WIDTH{sub}};
        carry     <= sub;
        cnt       <= '0;
        result    <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else if (step) begin
        carry  <= dcout;
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        result <= res_shift;
        cnt    <= cnt + CW'(1);
        if (last) begin
          carry_out <= dcout;
          overflow  <= dcout ^ dc_msb;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at DIGIT = 1, 2, 4, 8, 16 (WIDTH=16).
module tb_serial_addsub;

  localparam int NI = 5;
  localparam int DIGS[NI] = '{1, 2, 4, 8, 16};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] st;
  logic          sub;
  logic [15:0]   da, db;
  logic          busy[NI], done[NI], cout[NI], ovf[NI];
  logic [15:0]   res[NI];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_addsub #(.WIDTH(16), .DIGIT(DIGS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (st[g]),
      .sub       (sub),
      .data_a    (da),
      .data_b    (db),
      .busy      (busy[g]),
      .done      (done[g]),
      .result    (res[g]),
      .carry_out (cout[g]),
      .overflow  (ovf[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one start pulse at a negedge; returns at the negedge of busy cycle 1.
  task automatic start_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic s);
    da = a; db = b; sub = s; st[idx] = 1'b1;
    @(negedge clk);
    st[idx] = 1'b0;
    da = 16'($urandom); db = 16'($urandom); sub = 1'($urandom);
  endtask

  // Returns at the negedge where done is high; nb counts busy cycles seen on the way.
  task automatic wait_done(input int idx, output int nb);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (done[idx]) return;
      if (busy[idx]) nb++;
      @(negedge clk);
    end
    check("timeout_done", 32'(done[idx]), 1);
  endtask

  task automatic check_out(input string tag, input int idx, input logic [15:0] r,
                           input logic c, input logic v);
    check({tag, "_res"},  res[idx], r);
    check({tag, "_cout"}, cout[idx], c);
    check({tag, "_ovf"},  ovf[idx], v);
  endtask

  task automatic run(input string tag, input int idx, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [15:0] r, input logic c, input logic v);
    int nb;
    start_op(idx, a, b, s);
    wait_done(idx, nb);
    check({tag, "_busy"}, nb, 16 / DIGS[idx]);
    check_out(tag, idx, r, c, v);
    @(negedge clk);
    check({tag, "_pulse"}, done[idx], 0);
    check({tag, "_hold"}, res[idx], r);
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] be;
    logic [16:0] t;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {16'd0, s};
    return {(a[15] == be[15]) && (t[15] != a[15]), t[16], t[15:0]};
  endfunction

  initial begin
    int nb;
    logic [15:0] ra, rb;
    logic rs;
    logic [17:0] m;
    rst = 1'b1; st = '0; sub = 1'b0; da = '0; db = '0;
    @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check_out("rst", 0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run("add_basic", 0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run("add_wrap",  0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("add_ovf",   0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run("sub_borrow",0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run("sub_ovf",   0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Second start at busy cycle 5 must not disturb the running add.
    start_op(0, 16'h1111, 16'h2222, 1'b0);
    repeat (4) @(negedge clk);
    start_op(0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(0, nb);
    check("ignore_busy", nb, 11);
    check_out("ignore", 0, 16'h3333, 1'b0, 1'b0);

    // Back-to-back: new start issued in the done cycle.
    @(negedge clk);
    start_op(0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_done(0, nb);
    check_out("b2b_first", 0, 16'h1000, 1'b0, 1'b0);
    start_op(0, 16'h0003, 16'h0004, 1'b1);
    check("b2b_done_drop", done[0], 0);
    check("b2b_busy_up", busy[0], 1);
    wait_done(0, nb);
    check("b2b_busy", nb, 16);
    check_out("b2b_second", 0, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset at busy cycle 8.
    start_op(0, 16'h00FF, 16'h0F0F, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    check_out("midrst", 0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", busy[0], 0);
    run("after_rst", 0, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0);

    run("d4_add", 2, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      int idx;
      idx = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 3 : 4;
      for (int i = 0; i < 250; i++) begin
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
        if (i < 4) begin
          ra = (i < 2) ? 16'h8000 : 16'hFFFF;
          rb = (i[0]) ? 16'h8000 : 16'h7FFF;
        end
        m = model(ra, rb, rs);
        run("rand", idx, ra, rb, rs, m[15:0], m[16], m[17]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial/digit-serial add/subtract unit. Successor to the 16-bit single-bit serial adder.
- Processes DIGIT bits per clock, LSB first, over WIDTH-bit operands.
- Adds subtract mode, carry/borrow out, signed overflow, and a start/busy/done handshake.
- Sits beside the other serial datapath blocks in the accelerator, where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; legal values are 1, 2, 4, 8 and WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; operands and mode are captured on the edge where start=1 and busy=0.
- sub  input  1  mode captured with start: 0 computes A+B, 1 computes A-B.
- data_a  input  WIDTH  operand A.
- data_b  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  sum or difference; holds its value until the next accepted start.
- carry_out  output  1  final carry. In subtract mode, 1 means no borrow (A>=B unsigned).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0.
  - Shift registers, carry and counter are cleared; the in-flight operation is discarded.
- FSM states: IDLE, RUN. N = WIDTH/DIGIT.
- IDLE → RUN, on an edge with start=1:
  - a_sr<=data_a; b_sr<=data_b XOR {WIDTH{sub}}.
  - carry<=sub; cnt<=0; busy<=1; done<=0.
  - result<=0, carry_out<=0, overflow<=0.
- Each RUN edge:
  - {c, s} = a_sr[DIGIT-1:0] + b_sr[DIGIT-1:0] + carry, computed over DIGIT+1 bits.
  - carry<=c.
  - a_sr and b_sr shift right by DIGIT.
  - result shifts right by DIGIT, with s inserted at result[WIDTH-1 -: DIGIT].
  - cnt<=cnt+1; cnt is $clog2(N+1) bits wide.
- Last RUN edge (cnt==N-1):
  - state<=IDLE; busy<=0; done<=1.
  - carry_out<=c.
  - overflow<=(a_msb == b_eff_msb) && (s_msb != a_msb), using the MSBs of the final digit. b_eff is the inverted B in subtract mode.
- Latency:
  - start sampled at edge 0; done=1 in the cycle following edge N.
  - busy=1 for exactly N cycles.
  - With WIDTH=16: DIGIT=1 gives N=16, DIGIT=4 gives N=4.
- done:
  - High for exactly one cycle, then deasserts on the next edge.
  - A start accepted on that same edge is legal (back-to-back): the new operation begins and done drops.
- start while busy=1 is ignored: no reload, no effect on the operation in progress.
- data_a, data_b and sub are don't-care except on the accepted start edge.
- result, carry_out and overflow stay stable from done until the next accepted start.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package serial_pkg holds:
  - typedef enum logic {IDLE, RUN} ser_state_t
  - helper function for the counter width
  - legal-DIGIT check constant; an elaboration-time assertion uses it to reject illegal WIDTH/DIGIT combinations.
- One sub-module: serial_digit_adder, a combinational DIGIT-bit adder.
  - Ports: a, b, cin, sum, cout.
  - Also provides the internal MSB carry used for overflow.
- Operand shift registers stay inline.

Test Plan:
- WIDTH=16, DIGIT=1: A=0x1234, B=0x4321, sub=0, start → busy for 16 cycles; done in cycle 17; result=0x5555, carry_out=0, overflow=0.
- A=0xFFFF, B=0x0001, add → result=0x0000, carry_out=1, overflow=0. A=0x7FFF, B=0x0001, add → result=0x8000, overflow=1.
- Subtract A=0x0005, B=0x0007 → result=0xFFFE, carry_out=0 (borrow), overflow=0. Subtract A=0x8000, B=0x0001 → result=0x7FFF, overflow=1.
- start pulsed again at cycle 5 of a busy operation with different operands → ignored; original result produced on schedule. Back-to-back start in the done cycle → second result after a further 16 cycles.
- rst asserted at cycle 8 of an operation → all outputs 0 immediately; after release, a new start yields a correct result.
- WIDTH=16, DIGIT=4: A=0xABCD, B=0x1111 → done after 4 busy cycles; result=0xBCDE. Randomised sweep (1000 operations) against the reference model for DIGIT ∈ {1, 2, 8, 16}.
